mem_stage: RTL and testbench

Memory-access pipeline stage between `ex_mem` and `mem_wb`. Takes the destination register, write enable and ALU result from the EX/MEM register, plus a load/store opcode and store data. Performs loads and stores byte-serially over a byte-wide RAM port. Raises `stall_req` to freeze the upstream pipeline until the access completes, then presents write-back data to `mem_wb`.

---
 rtl/mem_stage.sv | 200 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage sitting between ex_mem and mem_wb. Loads and stores are
// carried out one byte per cycle over a byte-wide RAM port, little-endian,
// with no alignment restrictions (addresses wrap modulo 2^32). While an
// access is in flight, stall_req freezes everything upstream so the *_i
// inputs stay stable. All outputs are combinational; mem_wb registers them.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   mem_wd_i     in   destination register from ex_mem
//   mem_wreg_i   in   register write enable from ex_mem
//   mem_wdata_i  in   ALU result / effective address A
//   mem_op_i     in   0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW
//   mem_sdata_i  in   store data
//   ram_din      in   RAM read byte, valid the cycle after the address
//   ram_addr     out  RAM byte address
//   ram_dout     out  RAM write byte
//   ram_wr       out  1 = write ram_dout this cycle, 0 = read
//   stall_req    out  freeze upstream pipeline
//   wd_o         out  destination register to mem_wb
//   wreg_o       out  write enable to mem_wb
//   wdata_o      out  write-back data to mem_wb
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_sdata_i,
    input  logic [7:0]  ram_din,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_wr,
    output logic        stall_req,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic {IDLE, XFER} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [23:0] cap_buf;   // bytes 0..2 of a load captured so far

    logic        is_load;
    logic        is_store;
    logic [2:0]  len;       // access width in bytes
    logic [2:0]  byte_idx;  // byte being addressed this cycle
    logic        load_done;
    logic        store_last;
    logic [7:0]  store_byte;
    logic [31:0] load_raw;
    logic [31:0] load_result;

    // Sign or zero extension of the assembled load bytes.
    function automatic logic [31:0] extend(input logic [31:0] raw,
                                           input logic [3:0]  op);
        logic [31:0] res;
        case (op)
            OP_LB:   res = {{24{raw[7]}}, raw[7:0]};
            OP_LBU:  res = {24'd0, raw[7:0]};
            OP_LH:   res = {{16{raw[15]}}, raw[15:0]};
            OP_LHU:  res = {16'd0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Opcode decode; 9..15 fall through as NOP.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        len      = 3'd1;
        case (mem_op_i)
            OP_LB, OP_LBU: begin is_load  = 1'b1; len = 3'd1; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; len = 3'd2; end
            OP_LW:         begin is_load  = 1'b1; len = 3'd4; end
            OP_SB:         begin is_store = 1'b1; len = 3'd1; end
            OP_SH:         begin is_store = 1'b1; len = 3'd2; end
            OP_SW:         begin is_store = 1'b1; len = 3'd4; end
            default:       begin is_load  = 1'b0; is_store = 1'b0; end
        endcase
    end

    // Cycle 0 of every access is spent in IDLE, so the byte index is the
    // counter only once the FSM has moved into XFER.
    assign byte_idx   = (state == XFER) ? cnt : 3'd0;
    assign load_done  = (state == XFER) && (cnt == len);
    assign store_last = (byte_idx == (len - 3'd1));

    always_comb begin
        case (byte_idx[1:0])
            2'd0:    store_byte = mem_sdata_i[7:0];
            2'd1:    store_byte = mem_sdata_i[15:8];
            2'd2:    store_byte = mem_sdata_i[23:16];
            default: store_byte = mem_sdata_i[31:24];
        endcase
    end

    // The final byte is never captured; it is taken straight from ram_din
    // in the done cycle and placed above the buffered bytes.
    always_comb begin
        case (len)
            3'd1:    load_raw = {24'd0, ram_din};
            3'd2:    load_raw = {16'd0, ram_din, cap_buf[7:0]};
            default: load_raw = {ram_din, cap_buf};
        endcase
        load_result = extend(load_raw, mem_op_i);
    end

    // Output decode: everything is forced to zero while reset is asserted
    // so an aborted access never leaks a write strobe or partial data.
    always_comb begin
        ram_addr  = 32'd0;
        ram_dout  = 8'd0;
        ram_wr    = 1'b0;
        stall_req = 1'b0;
        wd_o      = 5'd0;
        wreg_o    = 1'b0;
        wdata_o   = 32'd0;
        if (!rst) begin
            wd_o = mem_wd_i;
            if (is_load) begin
                if (load_done) begin
                    wreg_o  = mem_wreg_i;
                    wdata_o = load_result;
                end else begin
                    ram_addr  = mem_wdata_i + {29'd0, byte_idx};
                    stall_req = 1'b1;
                end
            end else if (is_store) begin
                ram_addr  = mem_wdata_i + {29'd0, byte_idx};
                ram_dout  = store_byte;
                ram_wr    = 1'b1;
                stall_req = !store_last;
            end else begin
                wreg_o  = mem_wreg_i;
                wdata_o = mem_wdata_i;
            end
        end
    end

    // FSM, byte counter and capture buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            cap_buf <= 24'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_load) begin
                        state   <= XFER;
                        cnt     <= 3'd1;
                        cap_buf <= 24'd0;
                    end else if (is_store && !store_last) begin
                        state <= XFER;
                        cnt   <= 3'd1;
                    end
                end
                XFER: begin
                    if (is_load && !load_done) begin
                        case (cnt)
                            3'd1:    cap_buf[7:0]   <= ram_din;
                            3'd2:    cap_buf[15:8]  <= ram_din;
                            default: cap_buf[23:16] <= ram_din;
                        endcase
                        cnt <= cnt + 3'd1;
                    end else if (is_store && !store_last) begin
                        cnt <= cnt + 3'd1;
                    end else begin
                        // done cycle, or opcode dropped to NOP mid-access
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Bench for mem_stage: a byte RAM model with one-cycle read latency, a
// directed vector table, reset sequences, and a randomized run checked
// against a byte-array reference of memory contents.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [4:0]  mem_wd_i;
    logic        mem_wreg_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_sdata_i;
    logic [7:0]  ram_din;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic        stall_req;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .mem_wd_i    (mem_wd_i),
        .mem_wreg_i  (mem_wreg_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_op_i    (mem_op_i),
        .mem_sdata_i (mem_sdata_i),
        .ram_din     (ram_din),
        .ram_addr    (ram_addr),
        .ram_dout    (ram_dout),
        .ram_wr      (ram_wr),
        .stall_req   (stall_req),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: one-cycle read latency; preload port for the bench.
    logic [7:0]  ram [logic [31:0]];
    logic        pre_we;
    logic [31:0] pre_addr;
    logic [7:0]  pre_data;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] = pre_data;
        if (ram_wr === 1'b1) ram[ram_addr] = ram_dout;
        ram_din <= ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
    end

    // Reference memory image
    logic [7:0] ref_mem [logic [31:0]];

    int pass_cnt  = 0;
    int check_cnt = 0;

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int op_len(input logic [3:0] op);
        case (op)
            4'd3, 4'd8:       return 4;
            4'd2, 4'd5, 4'd7: return 2;
            default:          return 1;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic bit op_is_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    // Expected write-back value from the architectural meaning of each op.
    function automatic logic [31:0] model_expect(input logic [3:0]  op,
                                                 input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < op_len(op); k++)
            v = v | ({24'd0, ref_rd(a + 32'(k))} << (8 * k));
        case (op)
            4'd1:             return {{24{v[7]}}, v[7:0]};
            4'd2:             return {{16{v[15]}}, v[15:0]};
            4'd3, 4'd4, 4'd5: return v;
            4'd6, 4'd7, 4'd8: return 32'd0;
            default:          return a;
        endcase
    endfunction

    function automatic void model_store(input logic [3:0]  op,
                                        input logic [31:0] a,
                                        input logic [31:0] sd);
        if (op_is_store(op))
            for (int k = 0; k < op_len(op); k++)
                ref_mem[a + 32'(k)] = 8'((sd >> (8 * k)) & 32'hFF);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        check_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        else
            pass_cnt++;
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // Presents one instruction (called just after a rising edge) and follows
    // it to its done cycle, checking the RAM bus and write-back outputs.
    task automatic run_txn(input logic [3:0]  op,
                           input logic [31:0] a,
                           input logic [31:0] sd,
                           input logic [4:0]  wd,
                           input logic        wreg,
                           input logic [31:0] exp_wdata,
                           input string       tag);
        int n, exp_cyc, k;
        bit ld, st, done;
        ld = op_is_load(op);
        st = op_is_store(op);
        n  = op_len(op);
        exp_cyc = ld ? n + 1 : (st ? n : 1);
        mem_op_i    = op;
        mem_wdata_i = a;
        mem_sdata_i = sd;
        mem_wd_i    = wd;
        mem_wreg_i  = wreg;
        k    = 0;
        done = 0;
        while (!done && k < 10) begin
            @(negedge clk);
            if (st && k < n) begin
                chk($sformatf("%s addr c%0d", tag, k), ram_addr, a + 32'(k));
                chk($sformatf("%s wr c%0d", tag, k), {31'd0, ram_wr}, 32'd1);
                chk($sformatf("%s dout c%0d", tag, k), {24'd0, ram_dout},
                    (sd >> (8 * k)) & 32'hFF);
            end else if (ld && k < n) begin
                chk($sformatf("%s addr c%0d", tag, k), ram_addr, a + 32'(k));
                chk($sformatf("%s wr c%0d", tag, k), {31'd0, ram_wr}, 32'd0);
            end else begin
                chk($sformatf("%s addr c%0d", tag, k), ram_addr, 32'd0);
                chk($sformatf("%s wr c%0d", tag, k), {31'd0, ram_wr}, 32'd0);
            end
            if (stall_req === 1'b0) begin
                done = 1;
                chk($sformatf("%s cycles", tag), 32'(k + 1), 32'(exp_cyc));
                chk($sformatf("%s wdata", tag), wdata_o, exp_wdata);
                chk($sformatf("%s wreg", tag), {31'd0, wreg_o},
                    st ? 32'd0 : {31'd0, wreg});
                chk($sformatf("%s wd", tag), {27'd0, wd_o}, {27'd0, wd});
            end else begin
                chk($sformatf("%s wreg early c%0d", tag, k), {31'd0, wreg_o}, 32'd0);
            end
            @(posedge clk);
            #1;
            k++;
        end
        if (!done) begin
            check_cnt++;
            $display("FAIL %s timeout: stall_req still %b after %0d cycles, expected %0d",
                     tag, stall_req, k, exp_cyc);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] sd;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{4'd0,  32'hDEADBEEF, 32'h0,        5'd5,  1'b1, 32'hDEADBEEF};
        tbl[1]  = '{4'd3,  32'h00000100, 32'h0,        5'd1,  1'b1, 32'h12345678};
        tbl[2]  = '{4'd1,  32'h00000020, 32'h0,        5'd2,  1'b1, 32'hFFFFFF80};
        tbl[3]  = '{4'd4,  32'h00000020, 32'h0,        5'd3,  1'b1, 32'h00000080};
        tbl[4]  = '{4'd2,  32'hFFFFFFFF, 32'h0,        5'd4,  1'b1, 32'hFFFF8001};
        tbl[5]  = '{4'd5,  32'hFFFFFFFF, 32'h0,        5'd5,  1'b1, 32'h00008001};
        tbl[6]  = '{4'd8,  32'h0001FFFE, 32'hA1B2C3D4, 5'd6,  1'b1, 32'h00000000};
        tbl[7]  = '{4'd3,  32'h0001FFFE, 32'h0,        5'd7,  1'b0, 32'hA1B2C3D4};
        tbl[8]  = '{4'd6,  32'h0001FFFE, 32'h00000055, 5'd8,  1'b1, 32'h00000000};
        tbl[9]  = '{4'd4,  32'h0001FFFE, 32'h0,        5'd9,  1'b1, 32'h00000055};
        tbl[10] = '{4'd7,  32'h0001FFFF, 32'h00009977, 5'd10, 1'b1, 32'h00000000};
        tbl[11] = '{4'd2,  32'h0001FFFF, 32'h0,        5'd11, 1'b1, 32'hFFFF9977};
        tbl[12] = '{4'd12, 32'h0BADF00D, 32'h0,        5'd12, 1'b1, 32'h0BADF00D};
        tbl[13] = '{4'd3,  32'h0001FFFE, 32'h0,        5'd13, 1'b1, 32'hA1997755};

        pre_we      = 1'b0;
        pre_addr    = 32'd0;
        pre_data    = 8'd0;
        rst         = 1'b1;
        mem_op_i    = 4'd3;
        mem_wdata_i = 32'h100;
        mem_wd_i    = 5'd3;
        mem_wreg_i  = 1'b1;
        mem_sdata_i = 32'd0;

        // Reset held with an LW presented: outputs must stay zero
        repeat (2) @(posedge clk);
        #1;
        preload(32'h100, 8'h78);
        preload(32'h101, 8'h56);
        preload(32'h102, 8'h34);
        preload(32'h103, 8'h12);
        preload(32'h20, 8'h80);
        preload(32'hFFFFFFFF, 8'h01);
        preload(32'h0, 8'h80);
        @(negedge clk);
        chk("rst stall_req", {31'd0, stall_req}, 32'd0);
        chk("rst ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst ram_addr", ram_addr, 32'd0);
        chk("rst wd_o", {27'd0, wd_o}, 32'd0);
        chk("rst wreg_o", {31'd0, wreg_o}, 32'd0);
        chk("rst wdata_o", wdata_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, issued back to back
        for (int i = 0; i < 14; i++) begin
            run_txn(tbl[i].op, tbl[i].a, tbl[i].sd, tbl[i].wd, tbl[i].wreg,
                    tbl[i].exp, $sformatf("vec%0d", i));
            model_store(tbl[i].op, tbl[i].a, tbl[i].sd);
        end

        // Reset in cycle 2 of an LW aborts it
        mem_op_i    = 4'd3;
        mem_wdata_i = 32'h100;
        mem_wd_i    = 5'd7;
        mem_wreg_i  = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst stall_req", {31'd0, stall_req}, 32'd0);
        chk("midrst ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("midrst wreg_o", {31'd0, wreg_o}, 32'd0);
        chk("midrst wdata_o", wdata_o, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_op_i = 4'd0;
        @(negedge clk);
        chk("postrst stall_req", {31'd0, stall_req}, 32'd0);
        chk("postrst ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("postrst ram_addr", ram_addr, 32'd0);
        @(posedge clk);
        #1;
        run_txn(4'd3, 32'h100, 32'd0, 5'd7, 1'b1, 32'h12345678, "relw");

        // Randomized run against the reference memory image
        for (int i = 0; i < 32; i++)
            preload(32'h40 + 32'(i), 8'($urandom));
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] sd;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                a = 32'hFFFFFFFE + 32'($urandom_range(0, 3));
            else
                a = 32'h40 + 32'($urandom_range(0, 28));
            sd = $urandom;
            run_txn(op, a, sd, 5'($urandom), 1'($urandom), model_expect(op, a),
                    $sformatf("rnd%0d op%0d", i, op));
            model_store(op, a, sd);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
